// File: rtl/wb_arbiter.sv
// Write-back arbiter in front of the register file: ALU results win the single write port,
// MDU results wait in a small FIFO, and an age counter forces a one-cycle ALU hold to drain it.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [4:0]              alu_rd,
  input  logic [31:0]             alu_data,
  output logic                    alu_stall,
  input  logic                    mdu_valid,
  input  logic [4:0]              mdu_rd,
  input  logic [31:0]             mdu_data,
  output logic                    mdu_ready,
  output logic                    regwrite,
  output logic [4:0]              wr,
  output logic [31:0]             wd,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_LIMIT - 1);
  localparam logic [AGE_W-1:0] AGE_ZERO  = {AGE_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_e;

  logic [36:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AGE_W-1:0] age_q, age_d;
  state_e           state_q, state_d;
  logic             alu_stall_q, alu_stall_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       wr_q, wr_d;
  logic [31:0]      wd_q, wd_d;

  logic             mdu_ready_s;
  logic             push_s;
  logic             pop_s;
  logic             alu_take_s;
  logic [4:0]       head_rd_s;
  logic [31:0]      head_data_s;

  assign mdu_ready_s = (count_q != CNT_FULL);
  assign push_s      = mdu_valid && mdu_ready_s;
  assign alu_take_s  = alu_valid && !alu_stall_q;
  assign pop_s       = !alu_take_s && (count_q != CNT_ZERO);
  assign head_rd_s   = mem_q[rd_ptr_q][36:32];
  assign head_data_s = mem_q[rd_ptr_q][31:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Issue selection; x0 destinations consume the slot but never write.
  always_comb begin
    regwrite_d = 1'b0;
    wr_d       = wr_q;
    wd_d       = wd_q;
    if (alu_take_s) begin
      regwrite_d = (alu_rd != 5'd0);
      wr_d       = alu_rd;
      wd_d       = alu_data;
    end else if (pop_s) begin
      regwrite_d = (head_rd_s != 5'd0);
      wr_d       = head_rd_s;
      wd_d       = head_data_s;
    end else begin
      regwrite_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    case (state_q)
      IDLE: begin
        age_d = AGE_ZERO;
        if (count_d != CNT_ZERO) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (pop_s) begin
          age_d = AGE_ZERO;
          if (count_d == CNT_ZERO) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end else if (age_q == AGE_LIMIT) begin
          age_d   = AGE_ZERO;
          state_d = FORCE;
        end else begin
          age_d   = age_q + AGE_W'(1);
          state_d = WAIT;
        end
      end
      FORCE: begin
        age_d = AGE_ZERO;
        if (count_d != CNT_ZERO) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        age_d   = AGE_ZERO;
        state_d = IDLE;
      end
    endcase
    alu_stall_d = (state_d == FORCE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= CNT_ZERO;
      age_q       <= AGE_ZERO;
      state_q     <= IDLE;
      alu_stall_q <= 1'b0;
      regwrite_q  <= 1'b0;
      wr_q        <= 5'd0;
      wd_q        <= 32'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      age_q       <= age_d;
      state_q     <= state_d;
      alu_stall_q <= alu_stall_d;
      regwrite_q  <= regwrite_d;
      wr_q        <= wr_d;
      wd_q        <= wd_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_q[wr_ptr_q] <= {mdu_rd, mdu_data};
    end
  end

  assign alu_stall  = alu_stall_q;
  assign mdu_ready  = mdu_ready_s;
  assign regwrite   = regwrite_q;
  assign wr         = wr_q;
  assign wd         = wd_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with DEPTH=4, STARVE_LIMIT=8.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        regwrite;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_stall  (alu_stall),
    .mdu_valid  (mdu_valid),
    .mdu_rd     (mdu_rd),
    .mdu_data   (mdu_data),
    .mdu_ready  (mdu_ready),
    .regwrite   (regwrite),
    .wr         (wr),
    .wd         (wd),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int idx;
    int retired;
    int cyc;
    logic accept;

    rst = 1'b0; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hCAFE;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;

    // 1. reset held two cycles with ALU valid
    tick(); tick();
    check("rst_regwrite", 64'(regwrite), 64'd0);
    check("rst_wr", 64'(wr), 64'd0);
    check("rst_wd", 64'(wd), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_ready", 64'(mdu_ready), 64'd1);
    check("rst_stall", 64'(alu_stall), 64'd0);

    // 2. ALU only, then x0, then idle hold
    rst = 1'b1; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick();
    check("alu_regwrite", 64'(regwrite), 64'd1);
    check("alu_wr", 64'(wr), 64'd5);
    check("alu_wd", 64'(wd), 64'h1234);
    alu_rd = 5'd0; alu_data = 32'hBEEF;
    tick();
    check("x0_regwrite", 64'(regwrite), 64'd0);
    check("x0_wr", 64'(wr), 64'd0);
    check("x0_wd", 64'(wd), 64'hBEEF);
    alu_valid = 1'b0;
    tick();
    check("idle_regwrite", 64'(regwrite), 64'd0);
    check("idle_wd_hold", 64'(wd), 64'hBEEF);

    // 3. MDU into idle arbiter
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'd99;
    tick();
    check("mdu_nobypass", 64'(regwrite), 64'd0);
    check("mdu_count1", 64'(fifo_count), 64'd1);
    mdu_valid = 1'b0;
    tick();
    check("mdu_regwrite", 64'(regwrite), 64'd1);
    check("mdu_wr", 64'(wr), 64'd7);
    check("mdu_wd", 64'(wd), 64'd99);
    check("mdu_count0", 64'(fifo_count), 64'd0);

    // 4. fill with ALU always valid; five MDU results must retire in order
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA000;
    idx = 0; retired = 0; cyc = 0;
    mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'hD000_0000;
    while (retired < 5 && cyc < 150) begin
      accept = mdu_valid && mdu_ready;
      tick();
      cyc++;
      alu_data = 32'hA000 + 32'(cyc);
      if (regwrite && wr >= 5'd10) begin
        check("order_wr", 64'(wr), 64'(10 + retired));
        check("order_wd", 64'(wd), 64'(32'hD000_0000 + 32'(retired)));
        retired++;
      end
      if (accept) begin
        idx++;
        if (idx == 4) begin
          check("full_ready", 64'(mdu_ready), 64'd0);
          check("full_count", 64'(fifo_count), 64'd4);
        end
        if (idx == 5) begin
          mdu_valid = 1'b0;
        end else begin
          mdu_rd   = 5'(10 + idx);
          mdu_data = 32'hD000_0000 + 32'(idx);
        end
      end
    end
    check("fill_retired", 64'(retired), 64'd5);
    check("fill_accepted", 64'(idx), 64'd5);
    check("fill_drained", 64'(fifo_count), 64'd0);

    // 5. starvation: one entry, ALU valid every cycle
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h100;
    mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_data = 32'h5555;
    tick();
    mdu_valid = 1'b0;
    check("starve_count", 64'(fifo_count), 64'd1);
    check("starve_stall0", 64'(alu_stall), 64'd0);
    for (int k = 1; k <= 7; k++) begin
      alu_data = 32'h100 + 32'(k);
      tick();
      check("starve_nostall", 64'(alu_stall), 64'd0);
      check("starve_alu_wr", 64'(wr), 64'd2);
    end
    alu_data = 32'h108;
    tick();
    check("starve_stall", 64'(alu_stall), 64'd1);
    check("starve_pre_wd", 64'(wd), 64'h108);
    alu_data = 32'h109;
    tick();
    check("starve_force_rw", 64'(regwrite), 64'd1);
    check("starve_force_wr", 64'(wr), 64'd20);
    check("starve_force_wd", 64'(wd), 64'h5555);
    check("starve_stall_off", 64'(alu_stall), 64'd0);
    check("starve_empty", 64'(fifo_count), 64'd0);

    // 6. full FIFO with ALU idle: pop blocks push, push lands next cycle, then reset mid-stream
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h300;
    for (int k = 0; k < 4; k++) begin
      mdu_valid = 1'b1; mdu_rd = 5'(21 + k); mdu_data = 32'hE000 + 32'(k);
      tick();
    end
    check("sim_full_count", 64'(fifo_count), 64'd4);
    check("sim_full_ready", 64'(mdu_ready), 64'd0);
    alu_valid = 1'b0;
    mdu_valid = 1'b1; mdu_rd = 5'd25; mdu_data = 32'hE004;
    tick();
    check("sim_pop_wr", 64'(wr), 64'd21);
    check("sim_pop_count", 64'(fifo_count), 64'd3);
    check("sim_ready_back", 64'(mdu_ready), 64'd1);
    tick();
    mdu_valid = 1'b0;
    check("sim_pushpop_count", 64'(fifo_count), 64'd3);
    check("sim_pushpop_wr", 64'(wr), 64'd22);
    rst = 1'b0;
    tick();
    check("mid_rst_count", 64'(fifo_count), 64'd0);
    check("mid_rst_ready", 64'(mdu_ready), 64'd1);
    check("mid_rst_regwrite", 64'(regwrite), 64'd0);
    check("mid_rst_wd", 64'(wd), 64'd0);
    rst = 1'b1;
    tick();
    check("post_rst_regwrite", 64'(regwrite), 64'd0);
    check("post_rst_count", 64'(fifo_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
